// File: rtl/dfp_burst_adapter_if.sv
// Bundles the cache DFP line port and the bmem burst port of the burst adapter.
// The adapter uses the slave view; caches and memory models use the master view.
interface dfp_burst_adapter_if #(
    parameter int LINE_BITS  = 256,
    parameter int BURST_BITS = 64,
    parameter int ADDR_W     = 32
);
    logic [ADDR_W-1:0]     dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_BITS-1:0]  dfp_wdata;
    logic [LINE_BITS-1:0]  dfp_rdata;
    logic                  dfp_resp;

    logic [ADDR_W-1:0]     bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BURST_BITS-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [BURST_BITS-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/dfp_burst_adapter.sv
// Turns cache line reads/write-backs into four-beat bmem bursts.
// Write-backs win over reads so a dirty victim leaves before its replacement arrives.
module dfp_burst_adapter #(
    parameter int LINE_BITS  = 256,
    parameter int BURST_BITS = 64,
    parameter int ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dfp_burst_adapter_if.slave   bus
);
    localparam int BEATS    = LINE_BITS / BURST_BITS;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_COLLECT,
        WR_BURST,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_W-1:0]     beat_inc;
    logic [ADDR_W-1:0]     addr_q;
    logic [LINE_BITS-1:0]  rdata_q;
    logic [BURST_BITS-1:0] wdata_q;
    logic                  unused_offset_bits;

    assign beat_inc           = beat + 1'b1;
    assign unused_offset_bits = ^bus.dfp_addr[OFFSET_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.dfp_write) begin
                    next_state = WR_BURST;
                end else if (bus.dfp_read) begin
                    next_state = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (bus.bmem_ready) begin
                    next_state = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                if (bus.bmem_rvalid && beat == LAST_BEAT) begin
                    next_state = DONE;
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready && beat == LAST_BEAT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The outgoing write beat is registered one step ahead so no dfp input reaches bmem combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (bus.dfp_write || bus.dfp_read) begin
                        addr_q <= {bus.dfp_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    end
                    if (bus.dfp_write) begin
                        wdata_q <= bus.dfp_wdata[BURST_BITS-1:0];
                    end
                end
                RD_COLLECT: begin
                    if (bus.bmem_rvalid) begin
                        rdata_q[BURST_BITS*beat +: BURST_BITS] <= bus.bmem_rdata;
                        beat <= beat_inc;
                    end
                end
                WR_BURST: begin
                    if (bus.bmem_ready) begin
                        beat <= beat_inc;
                        if (beat == LAST_BEAT) begin
                            wdata_q <= '0;
                        end else begin
                            wdata_q <= bus.dfp_wdata[BURST_BITS*beat_inc +: BURST_BITS];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_read  = (state == RD_ISSUE);
    assign bus.bmem_write = (state == WR_BURST);
    assign bus.bmem_wdata = wdata_q;
    assign bus.dfp_rdata  = rdata_q;
    assign bus.dfp_resp   = (state == DONE);
endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Self-checking bench for dfp_burst_adapter; the bench plays both the caches and bmem,
// with scoreboard queues holding the write beats and read lines it expects to see.
module tb_dfp_burst_adapter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [63:0]  exp_beats[$];
    logic [255:0] exp_lines[$];
    logic [255:0] last_line;

    dfp_burst_adapter_if bus ();

    dfp_burst_adapter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] wdata);
        bus.dfp_read  = rd;
        bus.dfp_write = wr;
        bus.dfp_addr  = addr;
        bus.dfp_wdata = wdata;
    endtask

    // Acts as bmem for one write-back; stalls stall_len cycles when beat index stall_beat is offered.
    task automatic serve_write(input string name, input logic [31:0] addr, input logic [255:0] line,
                               input int stall_beat, input int stall_len, input bit junk);
        logic [31:0] exp_addr;
        logic [63:0] front;
        int  cyc        = 0;
        int  accepted   = 0;
        int  stall_left = stall_len;
        bit  done       = 0;
        bit  exp_resp;
        exp_addr = {addr[31:5], 5'b0};
        for (int i = 0; i < 4; i++) exp_beats.push_back(line[64*i +: 64]);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.bmem_ready  = 1'b0;
            bus.bmem_rvalid = 1'b0;
            if (junk) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata  = {$urandom, $urandom};
            end
            checks++;
            if (bus.bmem_read !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s bmem_read: got %b, expected 0 during write", name, bus.bmem_read);
            end
            if (bus.bmem_write === 1'b1) begin
                checks++;
                if (bus.bmem_addr !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL %s bmem_addr: got %h, expected %h", name, bus.bmem_addr, exp_addr);
                end
                checks++;
                if (exp_beats.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s extra beat: got %h, expected no further beat", name, bus.bmem_wdata);
                end else begin
                    front = exp_beats[0];
                    if (bus.bmem_wdata !== front) begin
                        errors++;
                        $display("[TB] FAIL %s bmem_wdata cycle %0d: got %h, expected %h", name, cyc, bus.bmem_wdata, front);
                    end
                end
                if (accepted == stall_beat && stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.bmem_ready = 1'b1;
                    if (exp_beats.size() > 0) void'(exp_beats.pop_front());
                    accepted++;
                end
            end
            exp_resp = (cyc == 5 + stall_len);
            checks++;
            if (bus.dfp_resp !== exp_resp) begin
                errors++;
                $display("[TB] FAIL %s dfp_resp cycle %0d: got %b, expected %b", name, cyc, bus.dfp_resp, exp_resp);
            end
            if (bus.dfp_resp === 1'b1) begin
                done = 1;
                bus.dfp_write = 1'b0;
                checks++;
                if (exp_beats.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL %s beats left: got %0d unsent, expected 0", name, exp_beats.size());
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no dfp_resp, expected one within 40 cycles", name);
            exp_beats.delete();
            bus.dfp_write = 1'b0;
        end
        @(negedge clk);
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        checks++;
        if ({bus.dfp_resp, bus.bmem_write, bus.bmem_read} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL %s after resp: got resp/write/read %b, expected 000", name,
                     {bus.dfp_resp, bus.bmem_write, bus.bmem_read});
        end
    endtask

    // Acts as bmem for one line read: holds off ready for stall cycles, then returns beats after lat cycles.
    task automatic serve_read(input string name, input logic [31:0] addr, input logic [255:0] line,
                              input int stall, input int lat);
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
        int  cyc        = 0;
        int  first_rd   = -1;
        int  pulses     = 0;
        int  acc        = -1;
        int  stall_left = stall;
        int  resp_at    = 6 + stall + lat;
        int  k;
        bit  done       = 0;
        bit  exp_resp;
        exp_addr = {addr[31:5], 5'b0};
        exp_lines.push_back(line);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.bmem_ready  = 1'b0;
            bus.bmem_rvalid = 1'b0;
            if (bus.bmem_read === 1'b1) begin
                pulses++;
                if (first_rd < 0) first_rd = cyc;
                checks++;
                if (bus.bmem_addr !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL %s bmem_addr: got %h, expected %h", name, bus.bmem_addr, exp_addr);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.bmem_ready = 1'b1;
                    acc = cyc;
                end
            end
            if (acc > 0) begin
                k = cyc - (acc + 1 + lat);
                if (k >= 0 && k < 4) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_rdata  = line[64*k +: 64];
                end
            end
            exp_resp = (cyc == resp_at);
            checks++;
            if (bus.dfp_resp !== exp_resp) begin
                errors++;
                $display("[TB] FAIL %s dfp_resp cycle %0d: got %b, expected %b", name, cyc, bus.dfp_resp, exp_resp);
            end
            if (bus.dfp_resp === 1'b1) begin
                done = 1;
                bus.dfp_read = 1'b0;
                exp_line = exp_lines.pop_front();
                last_line = exp_line;
                checks++;
                if (bus.dfp_rdata !== exp_line) begin
                    errors++;
                    $display("[TB] FAIL %s dfp_rdata: got %h, expected %h", name, bus.dfp_rdata, exp_line);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no dfp_resp, expected one within 60 cycles", name);
            exp_lines.delete();
            bus.dfp_read = 1'b0;
        end
        checks++;
        if (first_rd != 1) begin
            errors++;
            $display("[TB] FAIL %s issue cycle: got %0d, expected 1", name, first_rd);
        end
        checks++;
        if (pulses != stall + 1) begin
            errors++;
            $display("[TB] FAIL %s bmem_read cycles: got %0d, expected %0d", name, pulses, stall + 1);
        end
        @(negedge clk);
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        checks++;
        if ({bus.dfp_resp, bus.bmem_read} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s after resp: got resp/read %b, expected 00", name, {bus.dfp_resp, bus.bmem_read});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = 64'h0;
        last_line = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.dfp_resp, bus.bmem_read, bus.bmem_write} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset ctrl: got resp/read/write %b, expected 000",
                     {bus.dfp_resp, bus.bmem_read, bus.bmem_write});
        end
        checks++;
        if (bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset bus: got addr %h wdata %h, expected 0", bus.bmem_addr, bus.bmem_wdata);
        end
        checks++;
        if (bus.dfp_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL reset rdata: got %h, expected 0", bus.dfp_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.dfp_resp, bus.bmem_read, bus.bmem_write} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle after reset: got resp/read/write %b, expected 000",
                     {bus.dfp_resp, bus.bmem_read, bus.bmem_write});
        end
    endtask

    task automatic test_read();
        logic [255:0] line;
        for (int i = 0; i < 4; i++) line[64*i +: 64] = {16{i[3:0]}};
        applyStimulus(1'b1, 1'b0, 32'h1234_567F, 256'h0);
        @(negedge clk);
        checks++;
        if (bus.bmem_addr !== 32'h1234_5660 || bus.bmem_read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read issue: got addr %h read %b, expected 12345660 1", bus.bmem_addr, bus.bmem_read);
        end
        // Rewind one cycle of bookkeeping: serve_read expects to see the issue cycle first.
        bus.bmem_ready = 1'b0;
        serve_read_from_issue("read", line);
    endtask

    // Finishes a read whose issue cycle was already observed: accept now, stream beats, check resp.
    task automatic serve_read_from_issue(input string name, input logic [255:0] line);
        int  cyc  = 1;
        bit  done = 0;
        bit  exp_resp;
        bus.bmem_ready = 1'b1;
        exp_lines.push_back(line);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            bus.bmem_ready  = 1'b0;
            bus.bmem_rvalid = 1'b0;
            if (cyc >= 2 && cyc <= 5) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata  = line[64*(cyc-2) +: 64];
            end
            checks++;
            if (bus.bmem_read !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s single pulse cycle %0d: got bmem_read %b, expected 0", name, cyc, bus.bmem_read);
            end
            exp_resp = (cyc == 6);
            checks++;
            if (bus.dfp_resp !== exp_resp) begin
                errors++;
                $display("[TB] FAIL %s dfp_resp cycle %0d: got %b, expected %b", name, cyc, bus.dfp_resp, exp_resp);
            end
            if (bus.dfp_resp === 1'b1) begin
                done = 1;
                bus.dfp_read = 1'b0;
                last_line = exp_lines.pop_front();
                checks++;
                if (bus.dfp_rdata !== last_line) begin
                    errors++;
                    $display("[TB] FAIL %s dfp_rdata: got %h, expected %h", name, bus.dfp_rdata, last_line);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no dfp_resp, expected one within 20 cycles", name);
            exp_lines.delete();
            bus.dfp_read = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.dfp_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s resp width: got %b, expected 0", name, bus.dfp_resp);
        end
    endtask

    task automatic test_read_stall();
        logic [255:0] line = {64'hDEAD_BEEF_0000_0004, 64'h0123_4567_89AB_CDEF,
                              64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_0F0F_F0F0};
        applyStimulus(1'b1, 1'b0, 32'hCAFE_BA9C, 256'h0);
        serve_read("read_stall", 32'hCAFE_BA9C, line, 3, 2);
    endtask

    task automatic test_write_backpressure();
        logic [63:0]  a = 64'hAAAA_AAAA_AAAA_AAAA;
        logic [63:0]  b = 64'hBBBB_BBBB_BBBB_BBBB;
        logic [63:0]  c = 64'hCCCC_CCCC_CCCC_CCCC;
        logic [63:0]  d = 64'hDDDD_DDDD_DDDD_DDDD;
        logic [255:0] line;
        line = {d, c, b, a};
        applyStimulus(1'b0, 1'b1, 32'h8000_0045, line);
        serve_write("write_bp", 32'h8000_0045, line, 1, 2, 1'b0);
        checks++;
        if (bus.dfp_rdata !== last_line) begin
            errors++;
            $display("[TB] FAIL write keeps rdata: got %h, expected %h", bus.dfp_rdata, last_line);
        end
    endtask

    task automatic test_spurious_rvalid();
        logic [255:0] line = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                              64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
        for (int i = 0; i < 3; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (bus.dfp_rdata !== last_line || bus.dfp_resp !== 1'b0 || bus.bmem_read !== 1'b0) begin
                errors++;
                $display("[TB] FAIL spurious idle: got rdata %h resp %b read %b, expected %h 0 0",
                         bus.dfp_rdata, bus.dfp_resp, bus.bmem_read, last_line);
            end
        end
        bus.bmem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, line);
        serve_write("spurious_wr", 32'h0000_1000, line, 0, 0, 1'b1);
        checks++;
        if (bus.dfp_rdata !== last_line) begin
            errors++;
            $display("[TB] FAIL spurious rdata: got %h, expected %h", bus.dfp_rdata, last_line);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wline = {64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0002,
                               64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0000};
        logic [255:0] rline = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                               64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        applyStimulus(1'b1, 1'b1, 32'h4000_00E0, wline);
        serve_write("rw_write", 32'h4000_00E0, wline, 3, 1, 1'b0);
        serve_read("rw_read", 32'h4000_00E0, rline, 0, 1);
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        logic [255:0] rline = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        applyStimulus(1'b0, 1'b1, 32'h2000_0020, line);
        repeat (2) begin
            @(negedge clk);
            bus.bmem_ready = 1'b1;
        end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        checks++;
        if (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== line[128 +: 64]) begin
            errors++;
            $display("[TB] FAIL mid beat2: got write %b wdata %h, expected 1 %h",
                     bus.bmem_write, bus.bmem_wdata, line[128 +: 64]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dfp_resp, bus.bmem_read, bus.bmem_write} !== 3'b000 || bus.bmem_addr !== 32'h0 ||
            bus.bmem_wdata !== 64'h0 || bus.dfp_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL async reset: got resp/read/write %b addr %h wdata %h, expected all 0",
                     {bus.dfp_resp, bus.bmem_read, bus.bmem_write}, bus.bmem_addr, bus.bmem_wdata);
        end
        last_line = '0;
        bus.dfp_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.dfp_resp, bus.bmem_read, bus.bmem_write} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL no resp after abort cycle %0d: got resp/read/write %b, expected 000",
                         i, {bus.dfp_resp, bus.bmem_read, bus.bmem_write});
            end
        end
        applyStimulus(1'b1, 1'b0, 32'h2000_0020, 256'h0);
        serve_read("post_reset_read", 32'h2000_0020, rline, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        $display("[TB] read");
        test_read();
        $display("[TB] read with issue stall");
        test_read_stall();
        $display("[TB] write with backpressure");
        test_write_backpressure();
        $display("[TB] spurious rvalid");
        test_spurious_rvalid();
        $display("[TB] simultaneous read and write");
        test_back_to_back();
        $display("[TB] reset during write burst");
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dfp_burst_adapter.md
# dfp_burst_adapter

Memory-side responder for the cache downstream port (DFP): it serves 256-bit line reads and write-backs issued by the instruction and data caches during allocation. Each line request becomes four 64-bit bursts on the banked burst memory (bmem): bursts are collected into a line for reads and split out of a line for writes. It sits between the cache miss FSMs (PASS_THRU / ALLOCATE / ALLOCATE_STALL) and bmem.

## Interface
- Parameters:
- LINE_BITS, 256, cache line width (32-byte line, 5-bit offset)
- BURST_BITS, 64, bmem beat width; BEATS = LINE_BITS/BURST_BITS = 4
- ADDR_W, 32, byte address width
- Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dfp_addr  in  ADDR_W  line address from cache; offset bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  LINE_BITS  write line, stable while dfp_write high
- dfp_rdata  out  LINE_BITS  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_W  line-aligned address {dfp_addr[31:5], 5'b0}
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BURST_BITS  write beat data
- bmem_ready  in  1  bmem accepts command/beat this cycle
- bmem_rdata  in  BURST_BITS  returned beat
- bmem_rvalid  in  1  returned beat valid

## Operation
- FSM states: IDLE, RD_ISSUE, RD_COLLECT, WR_BURST, DONE. 2-bit beat counter `beat`.
- IDLE: sample requests. dfp_write has priority over dfp_read, so a dirty write-back goes first; next state WR_BURST. Otherwise dfp_read goes to RD_ISSUE. Latch the aligned address in both cases. beat <= 0.
- RD_ISSUE: bmem_read=1, bmem_addr=latched. When bmem_ready=1, go to RD_COLLECT. Otherwise hold.
- RD_COLLECT: each bmem_rvalid writes bmem_rdata into dfp_rdata[64*beat +: 64] and increments beat. The beat arriving with beat==3 moves the FSM to DONE.
- WR_BURST: bmem_write=1, bmem_addr=latched, bmem_wdata=dfp_wdata[64*beat +: 64]. A beat is accepted when bmem_ready=1, which increments beat. If bmem_ready=0, hold the same beat. The accepted beat with beat==3 moves the FSM to DONE.
- DONE: dfp_resp=1 for exactly one cycle, then IDLE. Requests are not sampled in DONE.
- After IDLE is re-entered, a request still high is a new request. Requesters drop the request in the cycle after dfp_resp (ALLOCATE_STALL).
- bmem_rvalid outside RD_COLLECT is dropped; no state change.
- dfp_rdata keeps the last completed line until overwritten by the next read. Writes do not alter it.
- beat wraps 3 -> 0 only via FSM exit. Counter arithmetic is 2-bit modulo.

## Timing
- Reset (async assert, sync release): state=IDLE, beat=0, dfp_rdata=0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
- Reset mid-burst aborts the transaction; no dfp_resp follows.
- Read: request seen in IDLE at edge N; bmem_read high in cycle N+1; with bmem_ready=1, leaves after one cycle. If the 4th rvalid is at cycle M, dfp_resp=1 and dfp_rdata is valid in cycle M+1.
- Minimum read latency (request to resp) = 2 + memory latency + 4 beats.
- Write: bmem_write high cycles N+1..N+4 with bmem_ready=1; dfp_resp in N+5. Each ready=0 cycle adds one.
- Outputs are registered/state-decoded only; there is no combinational path from dfp_* to bmem_*.
- dfp_read and dfp_write asserted together in IDLE: write serviced; read remains pending and is served after the write's DONE.

## Test plan
- Reset: assert rst_n=0 mid-WR_BURST at beat 2 -> all outputs 0 immediately, no dfp_resp; after release, IDLE.
- Read: dfp_addr=0x1234_567F, memory returns beats 0x0..0, 0x1..1, 0x2..2, 0x3..3 (64-bit repeats) -> bmem_addr=0x1234_5660, single bmem_read pulse, dfp_rdata={0x3..3,0x2..2,0x1..1,0x0..0}, one-cycle dfp_resp the cycle after beat 3.
- Write with backpressure: dfp_wdata=beats A,B,C,D, bmem_ready low on the 2nd beat for 2 cycles -> bmem_wdata sequence A,B,B,B,C,D; dfp_resp 7 cycles after request sampling.
- Read stall: bmem_ready=0 for 3 cycles in RD_ISSUE -> bmem_read held with stable address; result correct.
- Simultaneous read+write held: write completes with resp, requester drops write, keeps read -> read issued from IDLE next cycle, second resp.
- Spurious bmem_rvalid in IDLE/WR_BURST -> dfp_rdata unchanged, no resp, FSM unaffected.
